// File: rtl/sram_arbiter.sv
// Two-master SRAM-like bus arbiter: instruction fetch and load/store share
// one downstream port with at most one transaction outstanding.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   inst_*            : fetch master (read-only, word size)
//   data_*            : load/store master
//   rdata             : shared read data (mirrors mem_rdata)
//   mem_*             : downstream SRAM-like port
module sram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // owner encoding: 0 = inst, 1 = data
  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last_owner, last_nxt;
  logic        wr_q, wr_nxt;
  logic [1:0]  size_q, size_nxt;
  logic [3:0]  wstrb_q, wstrb_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic        pick_data;

  // On a tie the master not served last wins.
  assign pick_data = data_req & (~inst_req | ~last_owner);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      wstrb_q    <= 4'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      wr_q       <= wr_nxt;
      size_q     <= size_nxt;
      wstrb_q    <= wstrb_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    last_nxt     = last_owner;
    wr_nxt       = wr_q;
    size_nxt     = size_q;
    wstrb_nxt    = wstrb_q;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    unique case (state)
      IDLE: begin
        if (inst_req | data_req) begin
          state_nxt = REQ;
          owner_nxt = pick_data;
          if (pick_data) begin
            wr_nxt    = data_wr;
            size_nxt  = data_size;
            wstrb_nxt = data_wstrb;
            addr_nxt  = data_addr;
            wdata_nxt = data_wdata;
          end else begin
            wr_nxt    = 1'b0;
            size_nxt  = 2'b10;
            wstrb_nxt = 4'h0;
            addr_nxt  = inst_addr;
            wdata_nxt = 32'h0;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        // A data_ok arriving with addr_ok belongs to nothing yet.
        if (mem_addr_ok) begin
          state_nxt    = RESP;
          inst_addr_ok = ~owner;
          data_addr_ok = owner;
        end
      end
      RESP: begin
        if (mem_data_ok) begin
          state_nxt    = IDLE;
          last_nxt     = owner;
          inst_data_ok = ~owner;
          data_data_ok = owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = mem_rdata;

endmodule
